hazard_track_pipe: RTL and testbench

Parametrised hazard-tracking pipeline for the multi-stage CPU datapath. It follows every in-flight register-writing instruction through STAGES post-decode stages (E, M, W in the 5-stage core) and carries each one's destination and remaining-latency (Tnew) count. It answers NUM_READ decode-stage operand queries with a forwarded value, a ready flag and a global stall. It replaces the per-stage Tnew/regA3 plumbing and the fixed 2-bit forward selects, and keeps Tnew decrementing so that deeper pipelines and multi-cycle units work without rewiring.

---
 rtl/hazard_track_pipe_pkg.sv | 28 ++
 rtl/hazard_track_pipe_port_check.sv | 60 ++++++
 rtl/hazard_track_pipe.sv | 95 +++++++++
 tb/tb_hazard_track_pipe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_track_pipe_pkg.sv
// ----------------------------------------------------------------------------
// cpu_hazard_pkg
// Shared definitions for the hazard-tracking pipeline.
//   stage_entry_t : one in-flight register-writing instruction
//                   (valid, destination address, remaining latency Tnew)
//   ZERO_REG      : architectural zero register, never a forwarding source
//   TNEW_W_DEF    : default Tnew/Tuse counter width
//   tnew_dec      : saturating decrement of a Tnew count (widths up to
//                   TNEW_W_MAX bits; callers size-cast in and out)
// ----------------------------------------------------------------------------
package cpu_hazard_pkg;

   localparam int ZERO_REG   = 0;
   localparam int ADDR_W_DEF = 5;
   localparam int TNEW_W_DEF = 3;
   localparam int TNEW_W_MAX = 8;

   typedef struct packed {
      logic                  valid;
      logic [ADDR_W_DEF-1:0] addr;
      logic [TNEW_W_DEF-1:0] tnew;
   } stage_entry_t;

   function automatic logic [TNEW_W_MAX-1:0] tnew_dec(input logic [TNEW_W_MAX-1:0] t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction

endpackage

// File: rtl/hazard_track_pipe_port_check.sv
// ----------------------------------------------------------------------------
// hazard_port_check
// Resolves one decode-stage read port against all tracked stages.
//   i_valid/i_addr/i_tnew : flattened stage entries, stage 0 = youngest
//   i_rd_addr, i_rd_tuse  : operand source register and its Tuse
//   i_rf_data             : register-file read data for this port
//   i_stage_data          : forwardable result held in each stage
//   o_hazard              : youngest match is not ready in time -> stall
//   o_ready               : o_data is final this cycle
//   o_data                : operand after forwarding
// ----------------------------------------------------------------------------
module hazard_port_check
   import cpu_hazard_pkg::*;
#(
   parameter int STAGES = 3,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int TNEW_W = TNEW_W_DEF
)(
   input  logic [STAGES-1:0]        i_valid,
   input  logic [STAGES*ADDR_W-1:0] i_addr,
   input  logic [STAGES*TNEW_W-1:0] i_tnew,
   input  logic [ADDR_W-1:0]        i_rd_addr,
   input  logic [TNEW_W-1:0]        i_rd_tuse,
   input  logic [DATA_W-1:0]        i_rf_data,
   input  logic [STAGES*DATA_W-1:0] i_stage_data,
   output logic                     o_hazard,
   output logic                     o_ready,
   output logic [DATA_W-1:0]        o_data
);

   logic              w_hit;
   logic [TNEW_W-1:0] w_hit_tnew;
   logic [DATA_W-1:0] w_hit_data;
   logic              w_fwd;

   // Scan oldest to youngest so the youngest match overwrites older ones;
   // older producers of the same register are shadowed.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_tnew = '0;
      w_hit_data = '0;
      for (int s = STAGES - 1; s >= 0; s--) begin
         if (i_valid[s] && (i_addr[s*ADDR_W +: ADDR_W] == i_rd_addr) &&
             (i_rd_addr != ADDR_W'(ZERO_REG))) begin
            w_hit      = 1'b1;
            w_hit_tnew = i_tnew[s*TNEW_W +: TNEW_W];
            w_hit_data = i_stage_data[s*DATA_W +: DATA_W];
         end
      end
   end

   assign w_fwd    = w_hit && (w_hit_tnew == '0);
   assign o_hazard = w_hit && (w_hit_tnew > i_rd_tuse);
   // A pending-but-in-time producer leaves rf_data on the port as a
   // provisional value; the consumer picks up the real value further down.
   assign o_ready  = !w_hit || w_fwd;
   assign o_data   = w_fwd ? w_hit_data : i_rf_data;

endmodule

// File: rtl/hazard_track_pipe.sv
// ----------------------------------------------------------------------------
// hazard_track_pipe
// Tracks every in-flight register-writing instruction through STAGES
// post-decode stages with its destination and Tnew count, and answers
// NUM_READ decode-stage operand queries.
//   clk, reset (async, active-low)
//   issue_valid/issue_addr/issue_tnew : decoded instruction entering stage 0
//   flush                             : replace the decoded instruction by a bubble
//   rd_addr/rd_tuse/rf_data           : per-port operand queries
//   stage_data                        : forwardable result per stage
//   rd_data/rd_ready                  : per-port operand and readiness
//   stall                             : hold PC and IF/ID (combinational)
//   wb_valid/wb_addr                  : oldest stage, being written back
// ----------------------------------------------------------------------------
module hazard_track_pipe
   import cpu_hazard_pkg::*;
#(
   parameter int STAGES   = 3,
   parameter int NUM_READ = 2,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int TNEW_W   = TNEW_W_DEF
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       issue_valid,
   input  logic [ADDR_W-1:0]          issue_addr,
   input  logic [TNEW_W-1:0]          issue_tnew,
   input  logic                       flush,
   input  logic [NUM_READ*ADDR_W-1:0] rd_addr,
   input  logic [NUM_READ*TNEW_W-1:0] rd_tuse,
   input  logic [NUM_READ*DATA_W-1:0] rf_data,
   input  logic [STAGES*DATA_W-1:0]   stage_data,
   output logic [NUM_READ*DATA_W-1:0] rd_data,
   output logic [NUM_READ-1:0]        rd_ready,
   output logic                       stall,
   output logic                       wb_valid,
   output logic [ADDR_W-1:0]          wb_addr
);

   logic [STAGES-1:0]        r_valid;
   logic [STAGES*ADDR_W-1:0] r_addr;
   logic [STAGES*TNEW_W-1:0] r_tnew;
   logic [NUM_READ-1:0]      w_hazard;
   logic                     w_load;

   for (genvar p = 0; p < NUM_READ; p++) begin : g_port
      hazard_port_check #(
         .STAGES (STAGES),
         .ADDR_W (ADDR_W),
         .DATA_W (DATA_W),
         .TNEW_W (TNEW_W)
      ) u_check (
         .i_valid      (r_valid),
         .i_addr       (r_addr),
         .i_tnew       (r_tnew),
         .i_rd_addr    (rd_addr[p*ADDR_W +: ADDR_W]),
         .i_rd_tuse    (rd_tuse[p*TNEW_W +: TNEW_W]),
         .i_rf_data    (rf_data[p*DATA_W +: DATA_W]),
         .i_stage_data (stage_data),
         .o_hazard     (w_hazard[p]),
         .o_ready      (rd_ready[p]),
         .o_data       (rd_data[p*DATA_W +: DATA_W])
      );
   end

   assign stall  = |w_hazard;
   // A stalled or flushed decode slot enters stage 0 as a bubble; a flush
   // during a stall is not lost because IF/ID is held as well.
   assign w_load = issue_valid && !stall && !flush;

   // Stage 0 takes the decode slot; every older stage shifts unconditionally
   // with Tnew counting down to 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
         r_addr  <= '0;
         r_tnew  <= '0;
      end else begin
         r_valid[0]             <= w_load;
         r_addr[0 +: ADDR_W]    <= w_load ? issue_addr : '0;
         r_tnew[0 +: TNEW_W]    <= w_load ? issue_tnew : '0;
         for (int s = 1; s < STAGES; s++) begin
            r_valid[s]                <= r_valid[s-1];
            r_addr[s*ADDR_W +: ADDR_W] <= r_addr[(s-1)*ADDR_W +: ADDR_W];
            r_tnew[s*TNEW_W +: TNEW_W] <=
               TNEW_W'(tnew_dec(TNEW_W_MAX'(r_tnew[(s-1)*TNEW_W +: TNEW_W])));
         end
      end
   end

   assign wb_valid = r_valid[STAGES-1];
   assign wb_addr  = r_addr[(STAGES-1)*ADDR_W +: ADDR_W];

endmodule

// File: tb/tb_hazard_track_pipe.sv
module tb_hazard_track_pipe;

   localparam int STAGES   = 3;
   localparam int NUM_READ = 2;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int TNEW_W   = 3;

   logic                       clk;
   logic                       reset;
   logic                       issue_valid;
   logic [ADDR_W-1:0]          issue_addr;
   logic [TNEW_W-1:0]          issue_tnew;
   logic                       flush;
   logic [NUM_READ*ADDR_W-1:0] rd_addr;
   logic [NUM_READ*TNEW_W-1:0] rd_tuse;
   logic [NUM_READ*DATA_W-1:0] rf_data;
   logic [STAGES*DATA_W-1:0]   stage_data;
   logic [NUM_READ*DATA_W-1:0] rd_data;
   logic [NUM_READ-1:0]        rd_ready;
   logic                       stall;
   logic                       wb_valid;
   logic [ADDR_W-1:0]          wb_addr;

   hazard_track_pipe #(
      .STAGES   (STAGES),
      .NUM_READ (NUM_READ),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .TNEW_W   (TNEW_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .issue_valid (issue_valid),
      .issue_addr  (issue_addr),
      .issue_tnew  (issue_tnew),
      .flush       (flush),
      .rd_addr     (rd_addr),
      .rd_tuse     (rd_tuse),
      .rf_data     (rf_data),
      .stage_data  (stage_data),
      .rd_data     (rd_data),
      .rd_ready    (rd_ready),
      .stall       (stall),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Distinct, recognisable data sources
   localparam logic [31:0] RF0 = 32'hAF00_0000;
   localparam logic [31:0] RF1 = 32'hAF00_0001;
   localparam logic [31:0] SD0 = 32'h5D00_0000;
   localparam logic [31:0] SD1 = 32'h5D00_0001;
   localparam logic [31:0] SD2 = 32'h5D00_0002;

   typedef struct packed {
      logic        stall;
      logic        r0;
      logic [31:0] d0;
      logic        r1;
      logic [31:0] d1;
      logic        wbv;
      logic [4:0]  wba;
   } exp_t;

   exp_t  sb_q[$];
   string tag_q[$];
   int    n_chk = 0;
   int    n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic v, input logic [4:0] a, input logic [2:0] t);
      issue_valid = v;
      issue_addr  = a;
      issue_tnew  = t;
   endtask

   task automatic query(input int p, input logic [4:0] a, input logic [2:0] t);
      rd_addr[p*ADDR_W +: ADDR_W] = a;
      rd_tuse[p*TNEW_W +: TNEW_W] = t;
   endtask

   task automatic expect_out(input string tag, input logic st, input logic r0,
                             input logic [31:0] d0, input logic r1, input logic [31:0] d1,
                             input logic wbv, input logic [4:0] wba);
      exp_t e;
      e.stall = st; e.r0 = r0; e.d0 = d0; e.r1 = r1; e.d1 = d1; e.wbv = wbv; e.wba = wba;
      sb_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   // Compare the oldest expectation at the falling edge, then advance one cycle.
   task automatic cyc();
      exp_t  e;
      string t;
      @(negedge clk);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         t = tag_q.pop_front();
         chk({t, ".stall"}, 32'(stall), 32'(e.stall));
         chk({t, ".rdy0"},  32'(rd_ready[0]), 32'(e.r0));
         chk({t, ".data0"}, rd_data[0 +: DATA_W], e.d0);
         chk({t, ".rdy1"},  32'(rd_ready[1]), 32'(e.r1));
         chk({t, ".data1"}, rd_data[DATA_W +: DATA_W], e.d1);
         chk({t, ".wbv"},   32'(wb_valid), 32'(e.wbv));
         chk({t, ".wba"},   32'(wb_addr), 32'(e.wba));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      issue(1'b0, 5'd0, 3'd0);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      reset       = 1'b0;
      flush       = 1'b0;
      rd_addr     = '0;
      rd_tuse     = '0;
      rf_data     = {RF1, RF0};
      stage_data  = {SD2, SD1, SD0};
      // Valid issue while in reset must not load anything
      issue(1'b1, 5'd8, 3'd2);
      query(0, 5'd8, 3'd0);
      query(1, 5'd0, 3'd0);
      #1;
      expect_out("rst", 0, 1, RF0, 1, RF1, 0, 5'd0); cyc();
      expect_out("rst2", 0, 1, RF0, 1, RF1, 0, 5'd0); cyc();
      reset = 1'b1;

      // Load-use: producer tnew=2, consumer tuse=0
      issue(1'b1, 5'd8, 3'd2); query(0, 5'd1, 3'd0);
      expect_out("lu_iss", 0, 1, RF0, 1, RF1, 0, 5'd0); cyc();
      issue(1'b1, 5'd9, 3'd1); query(0, 5'd8, 3'd0);
      expect_out("lu_st1", 1, 0, RF0, 1, RF1, 0, 5'd0); cyc();
      expect_out("lu_st2", 1, 0, RF0, 1, RF1, 0, 5'd0); cyc();
      expect_out("lu_fwd", 0, 1, SD2, 1, RF1, 1, 5'd8); cyc();
      issue(1'b0, 5'd0, 3'd0); query(0, 5'd9, 3'd0);
      expect_out("lu_nx", 1, 0, RF0, 1, RF1, 0, 5'd0); cyc();
      expect_out("lu_nx2", 0, 1, SD1, 1, RF1, 0, 5'd0); cyc();
      expect_out("lu_wb", 0, 1, SD2, 1, RF1, 1, 5'd9); cyc();

      // ALU back-to-back: tnew=1, tuse=1
      issue(1'b1, 5'd3, 3'd1); query(0, 5'd0, 3'd0);
      expect_out("alu_iss", 0, 1, RF0, 1, RF1, 0, 5'd0); cyc();
      issue(1'b0, 5'd0, 3'd0); query(0, 5'd3, 3'd1);
      expect_out("alu_tuse", 0, 0, RF0, 1, RF1, 0, 5'd0); cyc();
      expect_out("alu_fwd", 0, 1, SD1, 1, RF1, 0, 5'd0); cyc();
      expect_out("alu_wb", 0, 1, SD2, 1, RF1, 1, 5'd3); cyc();

      // Shadowing of older producers of the same register
      issue(1'b1, 5'd5, 3'd0); query(0, 5'd0, 3'd0); query(1, 5'd0, 3'd0);
      expect_out("sh_iss", 0, 1, RF0, 1, RF1, 0, 5'd0); cyc();
      issue(1'b1, 5'd7, 3'd2); query(1, 5'd5, 3'd0);
      expect_out("sh_s0", 0, 1, RF0, 1, SD0, 0, 5'd0); cyc();
      issue(1'b1, 5'd5, 3'd0); query(0, 5'd7, 3'd2); query(1, 5'd5, 3'd0);
      expect_out("sh_s1", 0, 0, RF0, 1, SD1, 0, 5'd0); cyc();
      issue(1'b0, 5'd0, 3'd0); query(0, 5'd5, 3'd0); query(1, 5'd7, 3'd0);
      expect_out("sh_young", 1, 1, SD0, 0, RF1, 1, 5'd5); cyc();
      expect_out("sh_s2", 0, 1, SD1, 1, SD2, 1, 5'd7); cyc();
      expect_out("sh_old", 0, 1, SD2, 1, RF1, 1, 5'd5); cyc();
      query(1, 5'd0, 3'd0);

      // Register $0 never hazards or forwards
      issue(1'b1, 5'd0, 3'd3); query(0, 5'd0, 3'd0);
      expect_out("z_iss", 0, 1, RF0, 1, RF1, 0, 5'd0); cyc();
      issue(1'b0, 5'd0, 3'd0);
      expect_out("z_q", 0, 1, RF0, 1, RF1, 0, 5'd0); cyc();
      idle(3);

      // Flush together with stall: decode slot becomes a bubble
      issue(1'b1, 5'd8, 3'd3); query(0, 5'd0, 3'd0);
      expect_out("fs_iss", 0, 1, RF0, 1, RF1, 0, 5'd0); cyc();
      issue(1'b1, 5'd12, 3'd0); flush = 1'b1; query(0, 5'd8, 3'd0);
      expect_out("fs_both", 1, 0, RF0, 1, RF1, 0, 5'd0); cyc();
      flush = 1'b0; issue(1'b0, 5'd0, 3'd0); query(0, 5'd12, 3'd0);
      expect_out("fs_gone", 0, 1, RF0, 1, RF1, 0, 5'd0); cyc();
      expect_out("fs_wb8", 0, 1, RF0, 1, RF1, 1, 5'd8); cyc();
      expect_out("fs_wb0", 0, 1, RF0, 1, RF1, 0, 5'd0); cyc();

      // Asynchronous reset in the middle of a stall
      issue(1'b1, 5'd8, 3'd3); query(0, 5'd0, 3'd0);
      expect_out("rs_iss", 0, 1, RF0, 1, RF1, 0, 5'd0); cyc();
      issue(1'b0, 5'd0, 3'd0); query(0, 5'd8, 3'd0);
      expect_out("rs_stall", 1, 0, RF0, 1, RF1, 0, 5'd0); cyc();
      #1 reset = 1'b0;
      #1 chk("rs_imm.stall", 32'(stall), 32'd0);
      expect_out("rs_async", 0, 1, RF0, 1, RF1, 0, 5'd0); cyc();
      reset = 1'b1;
      expect_out("rs_after", 0, 1, RF0, 1, RF1, 0, 5'd0); cyc();

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
